weight_bit_serializer: RTL and testbench

WEIGHT_BIT_SERIALIZER -- requirements
Module: weight_bit_serializer

---
 rtl/weight_bit_serializer.sv | 124 ++++++++++++
 tb/tb_weight_bit_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bit_serializer.sv
// Converts a vector of signed weights to sign-magnitude and streams magnitude bit-columns to a bit-serial MAC.
// One PRIME cycle plus one cycle per presented column; in_ready only in IDLE and on the last column.
module weight_bit_serializer #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 8,
  parameter int SKIP_ZERO_COL = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] weight  [VEC_LENGTH],
  input  logic signed [DATA_WIDTH-1:0] act     [VEC_LENGTH],
  output logic signed [DATA_WIDTH-1:0] act_out [VEC_LENGTH],
  output logic        [VEC_LENGTH-1:0] sign,
  output logic        [VEC_LENGTH-1:0] w_bit,
  output logic                   [2:0] column_idx,
  output logic                         bit_valid,
  output logic                         vec_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    SERIAL = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] mag [VEC_LENGTH];
  logic [DATA_WIDTH-1:0] col_mask;
  logic [DATA_WIDTH-1:0] pend;
  logic [DATA_WIDTH-1:0] pend_clr;
  logic            [2:0] col;
  logic                  last;
  logic                  accept;

  // -128 wraps back to 8'h80, which is exactly its magnitude as unsigned.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] w);
    magnitude = w[DATA_WIDTH-1] ? DATA_WIDTH'(-w) : DATA_WIDTH'(w);
  endfunction

  function automatic logic [2:0] first_col(input logic [DATA_WIDTH-1:0] m);
    first_col = '0;
    for (int c = DATA_WIDTH - 1; c >= 0; c--) begin
      if (m[c]) first_col = 3'(c);
    end
  endfunction

  always_comb begin
    col_mask = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      col_mask = col_mask | magnitude(weight[j]);
    end
  end

  // pend holds the columns still to present, including the current one.
  assign pend_clr = pend & ~(DATA_WIDTH'(1) << col);
  assign last     = (state == SERIAL) && (pend_clr == '0);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    bit_valid  = 1'b0;
    vec_done   = 1'b0;
    column_idx = '0;
    w_bit      = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = PRIME;
      end
      PRIME: state_nxt = SERIAL;
      SERIAL: begin
        bit_valid  = 1'b1;
        column_idx = col;
        for (int j = 0; j < VEC_LENGTH; j++) begin
          w_bit[j] = mag[j][col];
        end
        if (last) begin
          vec_done  = 1'b1;
          in_ready  = 1'b1;
          state_nxt = in_valid ? PRIME : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) in_ready = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < VEC_LENGTH; j++) begin
        act_out[j] <= '0;
        mag[j]     <= '0;
      end
      sign <= '0;
      pend <= '0;
      col  <= '0;
    end else begin
      if (state == PRIME) begin
        col <= first_col(pend);
      end else if (state == SERIAL && !last) begin
        pend <= pend_clr;
        col  <= first_col(pend_clr);
      end
      if (accept) begin
        for (int j = 0; j < VEC_LENGTH; j++) begin
          act_out[j] <= act[j];
          sign[j]    <= weight[j][DATA_WIDTH-1];
          mag[j]     <= magnitude(weight[j]);
        end
        pend <= (SKIP_ZERO_COL != 0) ? col_mask : '1;
      end
    end
  end

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Bench for weight_bit_serializer: table vectors, hand sequences and random vectors against a column-list model.
module tb_weight_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              in_valid1, in_valid0, in_ready1, in_ready0;
  logic signed [7:0] weight_d [8];
  logic signed [7:0] act_d    [8];
  logic signed [7:0] act_out1 [8];
  logic signed [7:0] act_out0 [8];
  logic        [7:0] sign1, sign0, w_bit1, w_bit0;
  logic        [2:0] col1, col0;
  logic              bv1, bv0, vd1, vd0;

  weight_bit_serializer #(.DATA_WIDTH(8), .VEC_LENGTH(8), .SKIP_ZERO_COL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .weight(weight_d), .act(act_d), .act_out(act_out1), .sign(sign1), .w_bit(w_bit1),
    .column_idx(col1), .bit_valid(bv1), .vec_done(vd1));

  weight_bit_serializer #(.DATA_WIDTH(8), .VEC_LENGTH(8), .SKIP_ZERO_COL(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .weight(weight_d), .act(act_d), .act_out(act_out0), .sign(sign0), .w_bit(w_bit0),
    .column_idx(col0), .bit_valid(bv0), .vec_done(vd0));

  logic [63:0] ao1, ao0;
  for (genvar j = 0; j < 8; j++) begin : g_pack
    assign ao1[8*j +: 8] = act_out1[j];
    assign ao0[8*j +: 8] = act_out0[j];
  end

  logic        sel0;
  logic        o_ready, o_bv, o_vd;
  logic [7:0]  o_sign, o_wb;
  logic [2:0]  o_col;
  logic [63:0] o_act;
  assign o_ready = sel0 ? in_ready0 : in_ready1;
  assign o_bv    = sel0 ? bv0 : bv1;
  assign o_vd    = sel0 ? vd0 : vd1;
  assign o_sign  = sel0 ? sign0 : sign1;
  assign o_wb    = sel0 ? w_bit0 : w_bit1;
  assign o_col   = sel0 ? col0 : col1;
  assign o_act   = sel0 ? ao0 : ao1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  function automatic logic [7:0] lane_mag(input logic [7:0] b);
    int v;
    v = int'($signed(b));
    if (v < 0) v = -v;
    return v[7:0];
  endfunction

  function automatic logic [7:0] vec_mask(input logic [63:0] w);
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) m = m | lane_mag(w[8*j +: 8]);
    return m;
  endfunction

  function automatic longint dot(input logic [63:0] w, input logic [63:0] a);
    longint s;
    s = 0;
    for (int j = 0; j < 8; j++) s += longint'($signed(w[8*j +: 8])) * longint'($signed(a[8*j +: 8]));
    return s;
  endfunction

  // Offers one vector, then checks every cycle against the list of columns the weights call for.
  task automatic run_vector(input logic [63:0] w, input logic [63:0] a, input bit skip,
                            output int ncyc, output logic [7:0] colset, output longint mac);
    logic [7:0]        mg [8];
    logic [7:0]        mask, sg, exp_wb;
    logic signed [7:0] av;
    longint            t;
    int                cols [$];
    mask = vec_mask(w);
    for (int j = 0; j < 8; j++) begin
      mg[j] = lane_mag(w[8*j +: 8]);
      sg[j] = w[8*j + 7];
    end
    for (int c = 0; c < 8; c++) if (!skip || mask[c]) cols.push_back(c);
    if (cols.size() == 0) cols.push_back(0);
    ncyc = 0; colset = '0; mac = 0;
    sel0 = !skip;
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      weight_d[j] = w[8*j +: 8];
      act_d[j]    = a[8*j +: 8];
    end
    if (skip) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    chk("ready_idle", longint'(o_ready), 1);
    @(posedge clk);
    #1 in_valid1 = 1'b0; in_valid0 = 1'b0;
    @(negedge clk);
    chk("prime_bit_valid", longint'(o_bv), 0);
    chk("prime_w_bit", longint'(o_wb), 0);
    chk("prime_ready", longint'(o_ready), 0);
    chk("prime_done", longint'(o_vd), 0);
    chk("prime_col", longint'(o_col), 0);
    chk("prime_act_out", longint'(o_act), longint'(a));
    for (int k = 0; k < cols.size(); k++) begin
      @(negedge clk);
      for (int j = 0; j < 8; j++) exp_wb[j] = mg[j][cols[k]];
      chk("ser_bit_valid", longint'(o_bv), 1);
      chk("ser_col", longint'(o_col), longint'(cols[k]));
      chk("ser_w_bit", longint'(o_wb), longint'(exp_wb));
      chk("ser_sign", longint'(o_sign), longint'(sg));
      chk("ser_done", longint'(o_vd), longint'(k == cols.size() - 1));
      chk("ser_ready", longint'(o_ready), longint'(k == cols.size() - 1));
      if (o_bv) begin
        ncyc++;
        colset[o_col] = 1'b1;
        for (int j = 0; j < 8; j++) begin
          if (o_wb[j]) begin
            av = o_act[8*j +: 8];
            t = longint'(av) <<< o_col;
            mac += o_sign[j] ? -t : t;
          end
        end
      end
    end
    @(negedge clk);
    chk("idle_bit_valid", longint'(o_bv), 0);
    chk("idle_ready", longint'(o_ready), 1);
  endtask

  typedef struct {
    logic [63:0] w;
    logic [63:0] a;
    bit          skip;
    int          ncyc;
    logic [7:0]  colset;
    logic [7:0]  sgn;
    longint      mac;
  } vec_t;

  vec_t        tbl [6];
  int          n, vd_cnt;
  logic [7:0]  cs, m;
  longint      mac;
  logic [63:0] w, a;

  initial begin
    tbl[0] = '{w: {8{8'h05}}, a: {8{8'h03}}, skip: 1, ncyc: 2, colset: 8'h05, sgn: 8'h00, mac: 120};
    tbl[1] = '{w: {48'h0, 8'h7F, 8'h80}, a: {8{8'h01}}, skip: 1, ncyc: 8, colset: 8'hFF, sgn: 8'h01, mac: -1};
    tbl[2] = '{w: 64'h0, a: {8{8'h07}}, skip: 1, ncyc: 1, colset: 8'h01, sgn: 8'h00, mac: 0};
    tbl[3] = '{w: {8{8'hFF}}, a: {8{8'h02}}, skip: 0, ncyc: 8, colset: 8'hFF, sgn: 8'hFF, mac: -16};
    tbl[4] = '{w: 64'hF8_00_00_00_00_04_FE_01, a: {8{8'h01}}, skip: 1, ncyc: 4, colset: 8'h0F, sgn: 8'h82, mac: -5};
    tbl[5] = '{w: {8{8'h05}}, a: {8{8'h03}}, skip: 0, ncyc: 8, colset: 8'hFF, sgn: 8'h00, mac: 120};

    reset = 1'b1; in_valid1 = 1'b0; in_valid0 = 1'b0; sel0 = 1'b0;
    for (int j = 0; j < 8; j++) begin weight_d[j] = '0; act_d[j] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_ready", longint'(in_ready1), 0);
    chk("rst_bit_valid", longint'(bv1), 0);
    chk("rst_act_out", longint'(ao1), 0);
    chk("rst_sign", longint'(sign1), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", longint'(in_ready1), 1);
    chk("post_rst_ready0", longint'(in_ready0), 1);

    foreach (tbl[i]) begin
      run_vector(tbl[i].w, tbl[i].a, tbl[i].skip, n, cs, mac);
      chk("tbl_ncyc", longint'(n), longint'(tbl[i].ncyc));
      chk("tbl_colset", longint'(cs), longint'(tbl[i].colset));
      chk("tbl_mac", mac, tbl[i].mac);
      chk("tbl_sign_hold", longint'(o_sign), longint'(tbl[i].sgn));
      chk("tbl_act_hold", longint'(o_act), longint'(tbl[i].a));
    end

    // Back-to-back: second vector waits through PRIME and is taken on the last column edge.
    sel0 = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin weight_d[j] = 8'sd5; act_d[j] = 8'sd3; end
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) begin weight_d[j] = (j == 0) ? 8'sd3 : 8'sd0; act_d[j] = 8'sd9; end
    @(negedge clk);
    chk("b2b_prime_ready", longint'(in_ready1), 0);
    @(negedge clk);
    chk("b2b_a_col0", longint'(col1), 0);
    chk("b2b_a_act_held", longint'(ao1), longint'({8{8'h03}}));
    chk("b2b_a_ready0", longint'(in_ready1), 0);
    @(negedge clk);
    chk("b2b_a_col2", longint'(col1), 2);
    chk("b2b_a_done", longint'(vd1), 1);
    chk("b2b_a_ready_last", longint'(in_ready1), 1);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    chk("b2b_b_prime_bv", longint'(bv1), 0);
    chk("b2b_b_prime_ready", longint'(in_ready1), 0);
    chk("b2b_b_act", longint'(ao1), longint'({8{8'h09}}));
    @(negedge clk);
    chk("b2b_b_col0", longint'(col1), 0);
    chk("b2b_b_wbit0", longint'(w_bit1), 1);
    chk("b2b_b_done0", longint'(vd1), 0);
    @(negedge clk);
    chk("b2b_b_col1", longint'(col1), 1);
    chk("b2b_b_wbit1", longint'(w_bit1), 1);
    chk("b2b_b_done1", longint'(vd1), 1);
    @(negedge clk);
    chk("b2b_idle_ready", longint'(in_ready1), 1);

    // Reset landing between edges in the third SERIAL cycle of an 8-column vector.
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      weight_d[j] = (j == 0) ? -8'sd128 : ((j == 1) ? 8'sd127 : 8'sd0);
      act_d[j]    = 8'sd4;
    end
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_bit_valid", longint'(bv1), 1);
    chk("mid_col", longint'(col1), 2);
    #1 reset = 1'b1;
    #1;
    chk("arst_bit_valid", longint'(bv1), 0);
    chk("arst_w_bit", longint'(w_bit1), 0);
    chk("arst_col", longint'(col1), 0);
    chk("arst_done", longint'(vd1), 0);
    chk("arst_ready", longint'(in_ready1), 0);
    chk("arst_act_out", longint'(ao1), 0);
    chk("arst_sign", longint'(sign1), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_release_ready", longint'(in_ready1), 1);
    vd_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (vd1) vd_cnt++;
    end
    chk("arst_no_done", longint'(vd_cnt), 0);

    for (int r = 0; r < 24; r++) begin
      m = 8'($urandom_range(0, 255));
      for (int j = 0; j < 8; j++) begin
        w[8*j +: 8] = 8'($urandom) & m;
        a[8*j +: 8] = 8'($urandom);
      end
      if (r % 6 == 5) w = '0;
      run_vector(w, a, r[0], n, cs, mac);
      if (r[0]) chk("rnd_ncyc", longint'(n), (vec_mask(w) == 0) ? 1 : longint'($countones(vec_mask(w))));
      else      chk("rnd_ncyc", longint'(n), 8);
      chk("rnd_mac", mac, dot(w, a));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
